// File: rtl/dadder_pkg.sv
// Shared types, constants and BCD digit helpers for the sequential decimal adder.
package dadder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIXUP,
        DONE
    } dadder_state_t;

    localparam logic       DADDER_OP_ADD = 1'b1;
    localparam logic       DADDER_OP_SUB = 1'b0;
    localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

    function automatic logic [3:0] bcd_nines_comp(input logic [3:0] digit);
        return BCD_MAX_DIGIT - digit;
    endfunction

    function automatic logic bcd_digit_invalid(input logic [3:0] digit);
        return digit > BCD_MAX_DIGIT;
    endfunction

endpackage

// File: rtl/dadder_digit_slice.sv
// Combinational one-digit BCD adder: sum = a + b + cin with decimal correction.
module dadder_digit_slice (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [4:0] w_bin;

    always_comb begin
        w_bin = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
        if (w_bin > 5'd9) begin
            sum  = w_bin[3:0] + 4'd6;
            cout = 1'b1;
        end else begin
            sum  = w_bin[3:0];
            cout = 1'b0;
        end
    end

endmodule

// File: rtl/dadder_bcd_seq.sv
// Multi-digit packed-BCD adder/subtracter, DIGITS_PER_CYCLE digits per clock,
// least-significant slice first; subtraction yields sign-magnitude.
module dadder_bcd_seq
    import dadder_pkg::*;
#(
    parameter  int NUM_DIGITS       = 4,
    parameter  int DIGITS_PER_CYCLE = 1,
    localparam int DATA_WIDTH       = 4 * NUM_DIGITS
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_vld,
    output logic                  in_rdy,
    input  logic                  op,
    input  logic                  carry_in,
    input  logic [DATA_WIDTH-1:0] op_a,
    input  logic [DATA_WIDTH-1:0] op_b,
    output logic                  out_vld,
    input  logic                  out_rdy,
    output logic                  of_out,
    output logic                  err_out,
    output logic [DATA_WIDTH-1:0] data_out
);

    localparam int NSLICE  = NUM_DIGITS / DIGITS_PER_CYCLE;
    localparam int SLICE_W = 4 * DIGITS_PER_CYCLE;
    localparam int CNT_W   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    if (NUM_DIGITS % DIGITS_PER_CYCLE != 0) begin : g_bad_param
        $error("DIGITS_PER_CYCLE must divide NUM_DIGITS");
    end

    dadder_state_t         r_state, w_next;
    logic                  r_op, r_carry, r_of, r_err;
    logic [DATA_WIDTH-1:0] r_a, r_b, r_acc, r_dout;
    logic [CNT_W-1:0]      r_cnt;

    logic                  w_invalid, w_last, w_cout;
    logic [SLICE_W-1:0]    w_sa, w_sb, w_ssum;
    logic [DIGITS_PER_CYCLE:0] w_c;
    logic [DATA_WIDTH-1:0] w_acc_next;

    // Operands and accumulator shift right each slice so the active slice is
    // always at bit 0; result digits enter at the top and end up aligned.
    always_comb begin
        w_sa = '0;
        w_sb = '0;
        for (int unsigned d = 0; d < DIGITS_PER_CYCLE; d++) begin
            if (r_state == CALC) begin
                w_sa[4*d +: 4] = r_a[4*d +: 4];
                w_sb[4*d +: 4] = (r_op == DADDER_OP_ADD) ? r_b[4*d +: 4]
                                                         : bcd_nines_comp(r_b[4*d +: 4]);
            end else if (r_state == FIXUP) begin
                w_sb[4*d +: 4] = bcd_nines_comp(r_acc[4*d +: 4]);
            end
        end
    end

    assign w_c[0] = r_carry;
    for (genvar g = 0; g < DIGITS_PER_CYCLE; g++) begin : g_digit
        dadder_digit_slice u_digit (
            .a   (w_sa[4*g +: 4]),
            .b   (w_sb[4*g +: 4]),
            .cin (w_c[g]),
            .sum (w_ssum[4*g +: 4]),
            .cout(w_c[g+1])
        );
    end
    assign w_cout     = w_c[DIGITS_PER_CYCLE];
    assign w_acc_next = (r_acc >> SLICE_W) | (DATA_WIDTH'(w_ssum) << (DATA_WIDTH - SLICE_W));
    assign w_last     = (r_cnt == CNT_W'(NSLICE - 1));

    always_comb begin
        w_invalid = 1'b0;
        for (int unsigned d = 0; d < NUM_DIGITS; d++) begin
            if (bcd_digit_invalid(op_a[4*d +: 4]) || bcd_digit_invalid(op_b[4*d +: 4]))
                w_invalid = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:  if (in_vld) w_next = w_invalid ? DONE : CALC;
            CALC:  if (w_last) w_next = (r_op == DADDER_OP_ADD || w_cout) ? DONE : FIXUP;
            FIXUP: if (w_last) w_next = DONE;
            DONE:  if (out_rdy) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        in_rdy   = (r_state == IDLE);
        out_vld  = (r_state == DONE);
        of_out   = r_of;
        err_out  = r_err;
        data_out = r_dout;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_op    <= DADDER_OP_SUB;
            r_carry <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_dout  <= '0;
            r_of    <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (in_vld) begin
                    r_op    <= op;
                    r_a     <= op_a;
                    r_b     <= op_b;
                    r_carry <= (op == DADDER_OP_ADD) ? carry_in : 1'b1;
                    r_acc   <= '0;
                    r_cnt   <= '0;
                    if (w_invalid) begin
                        r_dout <= '0;
                        r_of   <= 1'b0;
                        r_err  <= 1'b1;
                    end
                end
                CALC, FIXUP: begin
                    r_a     <= r_a >> SLICE_W;
                    r_b     <= r_b >> SLICE_W;
                    r_acc   <= w_acc_next;
                    r_carry <= w_cout;
                    r_cnt   <= w_last ? '0 : r_cnt + 1'b1;
                    if (w_last) begin
                        if (r_state == FIXUP) begin
                            r_dout <= w_acc_next;
                            r_of   <= 1'b1;
                            r_err  <= 1'b0;
                        end else if (r_op == DADDER_OP_ADD || w_cout) begin
                            r_dout <= w_acc_next;
                            r_of   <= (r_op == DADDER_OP_ADD) ? w_cout : 1'b0;
                            r_err  <= 1'b0;
                        end else begin
                            r_carry <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dadder_bcd_seq.sv
// Directed bench: three instances (1, 2 and 4 digits per cycle) driven in lockstep.
module tb_dadder_bcd_seq;

    localparam int NSL [3] = '{4, 2, 1};

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_vld = 1'b0;
    logic        op = 1'b1;
    logic        carry_in = 1'b0;
    logic [15:0] op_a = '0;
    logic [15:0] op_b = '0;
    logic        out_rdy = 1'b0;

    logic [2:0]  in_rdy_v, out_vld_v, of_v, err_v;
    logic [15:0] dout [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dadder_bcd_seq #(.NUM_DIGITS(4), .DIGITS_PER_CYCLE(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .in_vld(in_vld), .in_rdy(in_rdy_v[0]), .op(op),
        .carry_in(carry_in), .op_a(op_a), .op_b(op_b), .out_vld(out_vld_v[0]),
        .out_rdy(out_rdy), .of_out(of_v[0]), .err_out(err_v[0]), .data_out(dout[0]));

    dadder_bcd_seq #(.NUM_DIGITS(4), .DIGITS_PER_CYCLE(2)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .in_vld(in_vld), .in_rdy(in_rdy_v[1]), .op(op),
        .carry_in(carry_in), .op_a(op_a), .op_b(op_b), .out_vld(out_vld_v[1]),
        .out_rdy(out_rdy), .of_out(of_v[1]), .err_out(err_v[1]), .data_out(dout[1]));

    dadder_bcd_seq #(.NUM_DIGITS(4), .DIGITS_PER_CYCLE(4)) u_dut4 (
        .clk(clk), .reset_n(reset_n), .in_vld(in_vld), .in_rdy(in_rdy_v[2]), .op(op),
        .carry_in(carry_in), .op_a(op_a), .op_b(op_b), .out_vld(out_vld_v[2]),
        .out_rdy(out_rdy), .of_out(of_v[2]), .err_out(err_v[2]), .data_out(dout[2]));

    task automatic chk(input string tag, input int idx, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s[dut%0d]: observed 0x%0h expected 0x%0h", tag, idx, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag, input logic [15:0] exp_d);
        for (int i = 0; i < 3; i++) begin
            chk({tag, "_in_rdy"}, i, 32'(in_rdy_v[i]), 32'd1);
            chk({tag, "_out_vld"}, i, 32'(out_vld_v[i]), 32'd0);
            chk({tag, "_data"}, i, 32'(dout[i]), 32'(exp_d));
        end
    endtask

    task automatic issue(input logic i_op, input logic i_cin, input logic [15:0] a,
                         input logic [15:0] b);
        @(negedge clk);
        for (int i = 0; i < 3; i++) chk("in_rdy_before_accept", i, 32'(in_rdy_v[i]), 32'd1);
        op = i_op; carry_in = i_cin; op_a = a; op_b = b; in_vld = 1'b1;
        @(posedge clk);
        #1 in_vld = 1'b0;
    endtask

    // kind: 0 = single pass, 1 = negative subtraction (two passes), 2 = invalid digit
    task automatic wait_res(input int kind);
        int lat [3];
        bit all_done;
        lat = '{0, 0, 0};
        all_done = 1'b0;
        for (int cyc = 1; cyc <= 20 && !all_done; cyc++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 3; i++) if (lat[i] == 0 && out_vld_v[i]) lat[i] = cyc;
            all_done = (lat[0] != 0) && (lat[1] != 0) && (lat[2] != 0);
        end
        for (int i = 0; i < 3; i++)
            chk("latency", i, 32'(lat[i]), (kind == 2) ? 32'd1 : 32'((kind + 1) * NSL[i]));
    endtask

    task automatic chk_res(input logic [15:0] exp_d, input logic exp_of, input logic exp_err);
        for (int i = 0; i < 3; i++) begin
            chk("out_vld", i, 32'(out_vld_v[i]), 32'd1);
            chk("data_out", i, 32'(dout[i]), 32'(exp_d));
            chk("of_out", i, 32'(of_v[i]), 32'(exp_of));
            chk("err_out", i, 32'(err_v[i]), 32'(exp_err));
        end
    endtask

    task automatic release_res();
        out_rdy = 1'b1;
        @(posedge clk);
        #1 out_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("out_vld_after_rdy", i, 32'(out_vld_v[i]), 32'd0);
            chk("in_rdy_after_rdy", i, 32'(in_rdy_v[i]), 32'd1);
        end
    endtask

    task automatic run(input logic i_op, input logic i_cin, input logic [15:0] a,
                       input logic [15:0] b, input int kind, input logic [15:0] exp_d,
                       input logic exp_of, input logic exp_err);
        issue(i_op, i_cin, a, b);
        wait_res(kind);
        chk_res(exp_d, exp_of, exp_err);
        release_res();
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk_idle_outputs("reset", 16'h0000);
        for (int i = 0; i < 3; i++) begin
            chk("reset_of", i, 32'(of_v[i]), 32'd0);
            chk("reset_err", i, 32'(err_v[i]), 32'd0);
        end
        @(negedge clk) reset_n = 1'b1;

        run(1'b1, 1'b0, 16'h1234, 16'h5678, 0, 16'h6912, 1'b0, 1'b0);
        run(1'b1, 1'b1, 16'h9999, 16'h0000, 0, 16'h0000, 1'b1, 1'b0);
        run(1'b0, 1'b1, 16'h0100, 16'h0001, 0, 16'h0099, 1'b0, 1'b0);
        run(1'b0, 1'b0, 16'h0005, 16'h0012, 1, 16'h0007, 1'b1, 1'b0);
        run(1'b0, 1'b0, 16'h4321, 16'h4321, 0, 16'h0000, 1'b0, 1'b0);
        run(1'b0, 1'b0, 16'h0000, 16'h9999, 1, 16'h9999, 1'b1, 1'b0);
        run(1'b1, 1'b0, 16'h00A1, 16'h0000, 2, 16'h0000, 1'b0, 1'b1);
        run(1'b1, 1'b0, 16'h0001, 16'h0001, 0, 16'h0002, 1'b0, 1'b0);

        // Back-pressure: result held while new operands are offered
        issue(1'b1, 1'b0, 16'h1234, 16'h5678);
        wait_res(0);
        op_a = 16'h1111; op_b = 16'h2222; in_vld = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 3; i++) begin
                chk("bp_out_vld", i, 32'(out_vld_v[i]), 32'd1);
                chk("bp_in_rdy", i, 32'(in_rdy_v[i]), 32'd0);
                chk("bp_data", i, 32'(dout[i]), 32'h6912);
            end
        end
        in_vld = 1'b0;
        chk_res(16'h6912, 1'b0, 1'b0);
        release_res();

        // Asynchronous reset during the computation
        issue(1'b0, 1'b0, 16'h0005, 16'h0012);
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        chk_idle_outputs("async_reset", 16'h0000);
        for (int i = 0; i < 3; i++) begin
            chk("async_reset_of", i, 32'(of_v[i]), 32'd0);
            chk("async_reset_err", i, 32'(err_v[i]), 32'd0);
        end
        @(negedge clk) reset_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk_idle_outputs("no_stale", 16'h0000);

        run(1'b1, 1'b1, 16'h0499, 16'h0500, 0, 16'h1000, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
